// File: rtl/led_bank_controller.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PWM modes on a shared prescaled time base.
// Optional macro LED_CTRL_BREATHE_EN adds a triangular breathing ramp to PWM mode.
module led_bank_controller #(
    parameter int  N_CH         = 4,
    parameter int  PRESCALE_DIV = 1000,
    parameter int  DUTY_W       = 8,
    localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_cfg_we,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [1:0]        i_cfg_mode,
    input  logic [3:0]        i_cfg_rate,
    input  logic [DUTY_W-1:0] i_cfg_duty,
    output logic              o_tick,
    output logic [N_CH-1:0]   o_led
);
    localparam int              PS_W    = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE_DIV - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PWM   = 2'b11
    } mode_t;

    logic [PS_W-1:0]   ps_cnt_r, ps_cnt_nxt_s;
    logic              tick_r, tick_nxt_s;
    logic [DUTY_W-1:0] phase_r, phase_nxt_s;
    logic [N_CH-1:0]   led_r, led_nxt_s;
    mode_t             mode_r     [N_CH];
    mode_t             mode_nxt_s [N_CH];
    logic [3:0]        rate_r     [N_CH];
    logic [3:0]        rate_nxt_s [N_CH];
    logic [DUTY_W-1:0] duty_r     [N_CH];
    logic [DUTY_W-1:0] duty_nxt_s [N_CH];
    logic [15:0]       bcnt_r     [N_CH];
    logic [15:0]       bcnt_nxt_s [N_CH];
    logic [DUTY_W-1:0] eff_duty_s [N_CH];
    logic [N_CH-1:0]   blink_r, blink_nxt_s;
    logic [N_CH-1:0]   wr_s, term_s;
    logic [31:0]       ch_ext_s;
    logic              in_range_s;

    assign ch_ext_s   = 32'(i_cfg_ch);
    assign in_range_s = (ch_ext_s < 32'(N_CH));

    // Shared time base: prescaler, registered tick and the common PWM phase counter.
    always_comb begin
        if (!i_enable) begin
            ps_cnt_nxt_s = '0;
        end else if (ps_cnt_r == PS_LAST) begin
            ps_cnt_nxt_s = '0;
        end else begin
            ps_cnt_nxt_s = ps_cnt_r + PS_W'(1);
        end
        tick_nxt_s = i_enable && (ps_cnt_nxt_s == PS_LAST);
        if (!i_enable) begin
            phase_nxt_s = '0;
        end else if (tick_r) begin
            phase_nxt_s = phase_r + DUTY_W'(1);
        end else begin
            phase_nxt_s = phase_r;
        end
    end

    // Per-channel config latch and blink counter; a write beats a same-cycle tick.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            wr_s[i]   = i_cfg_we && in_range_s && (ch_ext_s == 32'(i));
            term_s[i] = (bcnt_r[i] == ((16'd1 << rate_r[i]) - 16'd1));
            if (wr_s[i]) begin
                mode_nxt_s[i] = mode_t'(i_cfg_mode);
                rate_nxt_s[i] = i_cfg_rate;
                duty_nxt_s[i] = i_cfg_duty;
            end else begin
                mode_nxt_s[i] = mode_r[i];
                rate_nxt_s[i] = rate_r[i];
                duty_nxt_s[i] = duty_r[i];
            end
            if (!i_enable || wr_s[i]) begin
                bcnt_nxt_s[i]  = 16'd0;
                blink_nxt_s[i] = 1'b0;
            end else if (tick_r && term_s[i]) begin
                bcnt_nxt_s[i]  = 16'd0;
                blink_nxt_s[i] = ~blink_r[i];
            end else if (tick_r) begin
                bcnt_nxt_s[i]  = bcnt_r[i] + 16'd1;
                blink_nxt_s[i] = blink_r[i];
            end else begin
                bcnt_nxt_s[i]  = bcnt_r[i];
                blink_nxt_s[i] = blink_r[i];
            end
        end
    end

`ifdef LED_CTRL_BREATHE_EN
    logic [DUTY_W-1:0] eff_r     [N_CH];
    logic [DUTY_W-1:0] eff_nxt_s [N_CH];
    logic [N_CH-1:0]   up_r, up_nxt_s;

    // Breathing ramp: one step per blink-counter terminal tick, reversing at 0 and at the duty.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            if (!i_enable || wr_s[i]) begin
                eff_nxt_s[i] = '0;
                up_nxt_s[i]  = 1'b1;
            end else if (tick_r && term_s[i]) begin
                if (duty_r[i] == '0) begin
                    eff_nxt_s[i] = '0;
                    up_nxt_s[i]  = 1'b1;
                end else if (up_r[i]) begin
                    if (eff_r[i] >= duty_r[i]) begin
                        eff_nxt_s[i] = eff_r[i] - DUTY_W'(1);
                        up_nxt_s[i]  = 1'b0;
                    end else begin
                        eff_nxt_s[i] = eff_r[i] + DUTY_W'(1);
                        up_nxt_s[i]  = 1'b1;
                    end
                end else if (eff_r[i] == '0) begin
                    eff_nxt_s[i] = DUTY_W'(1);
                    up_nxt_s[i]  = 1'b1;
                end else begin
                    eff_nxt_s[i] = eff_r[i] - DUTY_W'(1);
                    up_nxt_s[i]  = 1'b0;
                end
            end else begin
                eff_nxt_s[i] = eff_r[i];
                up_nxt_s[i]  = up_r[i];
            end
            eff_duty_s[i] = eff_nxt_s[i];
        end
    end

    // Breathing ramp state registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            up_r <= '1;
            for (int i = 0; i < N_CH; i++) begin
                eff_r[i] <= '0;
            end
        end else begin
            up_r <= up_nxt_s;
            for (int i = 0; i < N_CH; i++) begin
                eff_r[i] <= eff_nxt_s[i];
            end
        end
    end
`else
    // Static duty: the programmed value drives the comparator directly.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            eff_duty_s[i] = duty_nxt_s[i];
        end
    end
`endif

    // Output decode from next-state values so the LED moves on the causing edge.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            if (!i_enable) begin
                led_nxt_s[i] = 1'b0;
            end else begin
                case (mode_nxt_s[i])
                    MODE_OFF:   led_nxt_s[i] = 1'b0;
                    MODE_ON:    led_nxt_s[i] = 1'b1;
                    MODE_BLINK: led_nxt_s[i] = blink_nxt_s[i];
                    MODE_PWM:   led_nxt_s[i] = (phase_nxt_s < eff_duty_s[i]);
                    default:    led_nxt_s[i] = 1'b0;
                endcase
            end
        end
    end

    // State update with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ps_cnt_r <= '0;
            tick_r   <= 1'b0;
            phase_r  <= '0;
            led_r    <= '0;
            blink_r  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                mode_r[i] <= MODE_OFF;
                rate_r[i] <= 4'd0;
                duty_r[i] <= '0;
                bcnt_r[i] <= 16'd0;
            end
        end else begin
            ps_cnt_r <= ps_cnt_nxt_s;
            tick_r   <= tick_nxt_s;
            phase_r  <= phase_nxt_s;
            led_r    <= led_nxt_s;
            blink_r  <= blink_nxt_s;
            for (int i = 0; i < N_CH; i++) begin
                mode_r[i] <= mode_nxt_s[i];
                rate_r[i] <= rate_nxt_s[i];
                duty_r[i] <= duty_nxt_s[i];
                bcnt_r[i] <= bcnt_nxt_s[i];
            end
        end
    end

    assign o_tick = tick_r;
    assign o_led  = led_r;

endmodule

// File: tb/tb_led_bank_controller.sv
// Scoreboard bench for led_bank_controller: a 4-channel DUT plus a 3-channel one for out-of-range writes.
module tb_led_bank_controller;
    localparam logic [1:0] M_OFF = 2'b00, M_ON = 2'b01, M_BLINK = 2'b10, M_PWM = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n, enable, cfg_we;
    logic [1:0] cfg_ch, cfg_mode;
    logic [3:0] cfg_rate;
    logic [7:0] cfg_duty;
    logic       tick, tick_s;
    logic [3:0] led;
    logic [2:0] led_s;

    led_bank_controller #(.N_CH(4), .PRESCALE_DIV(4), .DUTY_W(8)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_cfg_we(cfg_we),
        .i_cfg_ch(cfg_ch), .i_cfg_mode(cfg_mode), .i_cfg_rate(cfg_rate),
        .i_cfg_duty(cfg_duty), .o_tick(tick), .o_led(led)
    );

    led_bank_controller #(.N_CH(3), .PRESCALE_DIV(4), .DUTY_W(8)) u_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_cfg_we(cfg_we),
        .i_cfg_ch(cfg_ch), .i_cfg_mode(cfg_mode), .i_cfg_rate(cfg_rate),
        .i_cfg_duty(cfg_duty), .o_tick(tick_s), .o_led(led_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Combined LED view: {small[2:0], main[3:0]}
    typedef struct {
        int         at;
        logic [6:0] mask;
        logic [6:0] val;
        bit         chk_tick;
        bit         tv;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic push(input int at, input logic [6:0] mask, input logic [6:0] val,
                        input bit ct, input bit tv, input string nm);
        exp_t e;
        int   idx;
        e.at = at; e.mask = mask; e.val = val; e.chk_tick = ct; e.tv = tv; e.name = nm;
        idx = sb.size();
        while (idx > 0 && sb[idx-1].at > at) idx--;
        sb.insert(idx, e);
    endtask

    // Monitor: pops every expectation due this cycle and compares away from the active edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            m_e = sb.pop_front();
            n_chk++;
            if (m_e.at < cyc) begin
                n_fail++;
                $display("FAIL %s: check due at cycle %0d missed (now %0d)", m_e.name, m_e.at, cyc);
            end else if (((({led_s, led} ^ m_e.val) & m_e.mask) !== 7'd0) ||
                         (m_e.chk_tick && ({tick_s, tick} !== {m_e.tv, m_e.tv}))) begin
                n_fail++;
                $display("FAIL %s @%0d: led=%b tick=%b%b, required led=%b (mask %b) tick=%b",
                         m_e.name, cyc, {led_s, led}, tick_s, tick, m_e.val, m_e.mask, m_e.tv);
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [1:0] mode,
                             input logic [3:0] rate, input logic [7:0] duty);
        cfg_ch = ch; cfg_mode = mode; cfg_rate = rate; cfg_duty = duty; cfg_we = 1'b1;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    // Ticks occur in cycles 6,10,14,... while enable stays high after the first release.
    function automatic int phase_at(input int c);
        return ((c - 3) / 4) % 256;
    endfunction

    task automatic pwm_window(input logic [7:0] duty, input string nm);
        int eff, first, c;
        cfg_write(2'd1, M_PWM, 4'd0, duty);
        eff   = cyc;
        first = eff + ((3 - (eff % 4)) + 4) % 4;
        for (int j = 0; j < 256; j++) begin
            c = first + 4 * j;
            push(c, 7'b010_0010, (phase_at(c) < int'(duty)) ? 7'b010_0010 : 7'b000_0000, 1'b0, 1'b0, nm);
        end
        wait_cyc(first + 4 * 255 + 1);
    endtask

    int e_cyc, r_cyc, s_cyc;

    initial begin
        rst_n = 1'b0; enable = 1'b1; cfg_we = 1'b0;
        cfg_ch = 2'd0; cfg_mode = M_OFF; cfg_rate = 4'd0; cfg_duty = 8'd0;

        // Reset held for three edges, then tick cadence
        for (int c = 1; c <= 3; c++) push(c, 7'h7F, 7'h00, 1'b1, 1'b0, "reset");
        wait_cyc(3);
        rst_n = 1'b1;
        for (int c = 4; c <= 13; c++)
            push(c, 7'h7F, 7'h00, 1'b1, (c >= 6 && ((c - 6) % 4) == 0), "tick_cadence");

        // Blink ch0 rate 2, write sampled at edge 13
        wait_cyc(12);
        cfg_write(2'd0, M_BLINK, 4'd2, 8'd0);
        push(26, 7'h7F, 7'b000_0000, 1'b0, 1'b0, "blink_before_rise");
        push(27, 7'h7F, 7'b001_0001, 1'b0, 1'b0, "blink_first_rise");
        push(42, 7'h7F, 7'b001_0001, 1'b0, 1'b0, "blink_hold_high");
        push(43, 7'h7F, 7'b000_0000, 1'b0, 1'b0, "blink_fall");
        push(58, 7'h7F, 7'b000_0000, 1'b0, 1'b0, "blink_hold_low");
        push(59, 7'h7F, 7'b001_0001, 1'b0, 1'b0, "blink_second_rise");

        // PWM on ch1
        wait_cyc(60);
        pwm_window(8'd64,  "pwm_duty64");
        pwm_window(8'd0,   "pwm_duty0");
        pwm_window(8'd255, "pwm_duty255");

        // ON, then an out-of-range write on the 3-channel instance
        cfg_write(2'd2, M_ON, 4'd0, 8'd0);
        push(cyc, 7'b100_0100, 7'b100_0100, 1'b0, 1'b0, "ch2_on");
        cfg_write(2'd3, M_OFF, 4'd0, 8'd0);
        push(cyc,     7'b100_1100, 7'b100_0100, 1'b0, 1'b0, "out_of_range_ignored");
        push(cyc + 3, 7'b100_1100, 7'b100_0100, 1'b0, 1'b0, "out_of_range_hold");

        // Disable and re-enable
        wait_cyc(cyc + 4);
        e_cyc = cyc;
        enable = 1'b0;
        push(e_cyc + 1, 7'h7F, 7'h00, 1'b1, 1'b0, "disable_next_edge");
        push(e_cyc + 3, 7'h7F, 7'h00, 1'b1, 1'b0, "disable_hold");
        wait_cyc(e_cyc + 4);
        r_cyc = cyc;
        enable = 1'b1;
        push(r_cyc + 1,  7'h7F, 7'b110_0110, 1'b1, 1'b0, "reenable_cfg_kept");
        push(r_cyc + 2,  7'h7F, 7'b110_0110, 1'b1, 1'b0, "reenable_no_tick");
        push(r_cyc + 3,  7'h7F, 7'b110_0110, 1'b1, 1'b1, "reenable_first_tick");
        push(r_cyc + 15, 7'h7F, 7'b110_0110, 1'b0, 1'b0, "reenable_blink_low");
        push(r_cyc + 16, 7'h7F, 7'b111_0111, 1'b0, 1'b0, "reenable_blink_rise");

        // Reset mid-blink clears outputs and configuration
        wait_cyc(r_cyc + 20);
        s_cyc = cyc;
        rst_n = 1'b0;
        push(s_cyc + 1, 7'h7F, 7'h00, 1'b1, 1'b0, "midrun_reset");
        wait_cyc(s_cyc + 1);
        rst_n = 1'b1;
        push(s_cyc + 20, 7'h7F, 7'h00, 1'b0, 1'b0, "cfg_cleared_a");
        push(s_cyc + 40, 7'h7F, 7'h00, 1'b0, 1'b0, "cfg_cleared_b");

`ifdef LED_CTRL_BREATHE_EN
        // Ramp on ch3 written right after phase reaches 252; phase wraps while duty ramps 1,2,3,4,3,2,1,0
        begin
            logic [7:0] bexp;
            bexp = 8'b0001_1000;
            wait_cyc(s_cyc + 1009);
            cfg_write(2'd3, M_PWM, 4'd0, 8'd4);
            push(s_cyc + 1010, 7'h7F, 7'h00, 1'b0, 1'b0, "breathe_start");
            for (int k = 1; k <= 8; k++)
                push(s_cyc + 1 + 4 * (252 + k), 7'h7F, {3'b000, bexp[k-1], 3'b000}, 1'b0, 1'b0, "breathe_step");
        end
`endif

        wait_cyc(cyc + 1100);
        while (sb.size() > 0) begin
            m_e = sb.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL %s: never checked, due at cycle %0d", m_e.name, m_e.at);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
